// File: rtl/pico_ctrl_core.sv
`default_nettype none
// ============================================================================
// Module   : pico_ctrl_core
// Brief    : PicoCtrl micro-sequencer execution engine (fetch, decode, run).
// Revision : 1.0
// ============================================================================
module pico_ctrl_core #(
    parameter int ADDR_W   = 5,
    parameter int PRESCALE = 50000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic [1:0]        cond_in_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic [7:0]        reg0_o,
    output logic [7:0]        reg1_o,
    output logic [7:0]        reg2_o,
    output logic [7:0]        reg3_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              waiting_o,
    output logic              halted_o
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(PRESCALE - 1);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [2:0] A_WRITE = 3'b001;
    localparam logic [2:0] A_JUMP  = 3'b010;
    localparam logic [2:0] A_WAIT  = 3'b011;
    localparam logic [2:0] A_HALT  = 3'b100;

    logic [1:0]        meta_q, sync_q;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0][7:0]   regs_q, regs_d;
    logic [7:0]        tick_q, tick_d;
    logic [PRE_W-1:0]  pre_q, pre_d;

    logic [2:0] w_cond;
    logic [2:0] w_act;
    logic [1:0] w_sel;
    logic [7:0] w_imm;
    logic       w_cond_true;
    logic       w_c0, w_c1;

    assign w_cond = rom_data_i[15:13];
    assign w_act  = rom_data_i[12:10];
    assign w_sel  = rom_data_i[9:8];
    assign w_imm  = rom_data_i[7:0];
    assign w_c0   = sync_q[0];
    assign w_c1   = sync_q[1];

    always_comb begin
        w_cond_true = 1'b0;
        case (w_cond)
            3'b000:  w_cond_true = 1'b1;
            3'b001:  w_cond_true = ~w_c0;
            3'b010:  w_cond_true = w_c0;
            3'b011:  w_cond_true = ~w_c1;
            3'b100:  w_cond_true = w_c1;
            3'b101:  w_cond_true = w_c0 & w_c1;
            3'b110:  w_cond_true = w_c0 | w_c1;
            default: w_cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        regs_d  = regs_q;
        tick_d  = tick_q;
        pre_d   = pre_q;
        if (en_i) begin
            case (state_q)
                S_RUN: begin
                    pc_d = pc_q + 1'b1;
                    if (w_cond_true) begin
                        case (w_act)
                            A_WRITE: regs_d[w_sel] = w_imm;
                            A_JUMP:  pc_d = w_imm[ADDR_W-1:0];
                            A_WAIT: begin
                                // A zero-length wait degenerates to a nop.
                                if (w_imm != 8'd0) begin
                                    tick_d  = w_imm;
                                    pre_d   = '0;
                                    state_d = S_WAIT;
                                    pc_d    = pc_q;
                                end
                            end
                            A_HALT: begin
                                state_d = S_HALT;
                                pc_d    = pc_q;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WAIT: begin
                    if (pre_q == C_PRE_LAST) begin
                        pre_d = '0;
                        if (tick_q == 8'd1) begin
                            tick_d  = 8'd0;
                            state_d = S_RUN;
                            pc_d    = pc_q + 1'b1;
                        end else begin
                            tick_d = tick_q - 8'd1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q  <= 2'b00;
            sync_q  <= 2'b00;
            state_q <= S_RUN;
            pc_q    <= '0;
            regs_q  <= '0;
            tick_q  <= 8'd0;
            pre_q   <= '0;
        end else begin
            // Synchroniser keeps sampling even while the core is paused.
            meta_q  <= cond_in_i;
            sync_q  <= meta_q;
            state_q <= state_d;
            pc_q    <= pc_d;
            regs_q  <= regs_d;
            tick_q  <= tick_d;
            pre_q   <= pre_d;
        end
    end

    assign rom_addr_o = pc_q;
    assign pc_o       = pc_q;
    assign reg0_o     = regs_q[0];
    assign reg1_o     = regs_q[1];
    assign reg2_o     = regs_q[2];
    assign reg3_o     = regs_q[3];
    assign waiting_o  = (state_q == S_WAIT);
    assign halted_o   = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pico_ctrl_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pico_ctrl_core
// Brief    : Self-checking bench for pico_ctrl_core against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_pico_ctrl_core;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  cond_in;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  reg0, reg1, reg2, reg3;
    logic [4:0]  pc;
    logic        waiting, halted;
    logic [15:0] rom [32];

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: mode 0 run, 1 wait, 2 halt; wait tracked as cycles left.
    int         m_pc;
    logic [7:0] m_reg [4];
    int         m_mode;
    int         m_left;
    logic [1:0] s1, s2;

    assign rom_data = rom[rom_addr];

    pico_ctrl_core #(.ADDR_W(5), .PRESCALE(P)) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en), .cond_in_i(cond_in),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3),
        .pc_o(pc), .waiting_o(waiting), .halted_o(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input int c, input int a, input int s, input int imm);
        logic [15:0] w;
        w = {3'(c), 3'(a), 2'(s), 8'(imm)};
        return w;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_mode = 0; m_left = 0; s1 = 2'b00; s2 = 2'b00;
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    endtask

    task automatic model_step();
        logic [15:0] w;
        logic        ok;
        int          nxt;
        if (en) begin
            if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 0;
                    m_pc   = (m_pc + 1) % 32;
                end
            end else if (m_mode == 0) begin
                w   = rom[m_pc];
                nxt = (m_pc + 1) % 32;
                case (w[15:13])
                    3'd0: ok = 1'b1;
                    3'd1: ok = (s2[0] == 1'b0);
                    3'd2: ok = (s2[0] == 1'b1);
                    3'd3: ok = (s2[1] == 1'b0);
                    3'd4: ok = (s2[1] == 1'b1);
                    3'd5: ok = s2[0] && s2[1];
                    3'd6: ok = s2[0] || s2[1];
                    default: ok = 1'b0;
                endcase
                if (!ok) m_pc = nxt;
                else case (w[12:10])
                    3'd1: begin m_reg[w[9:8]] = w[7:0]; m_pc = nxt; end
                    3'd2: m_pc = int'(w[7:0]) % 32;
                    3'd3: if (w[7:0] == 8'd0) m_pc = nxt;
                          else begin m_mode = 1; m_left = int'(w[7:0]) * P; end
                    3'd4: m_mode = 2;
                    default: m_pc = nxt;
                endcase
            end
        end
        s2 = s1;
        s1 = cond_in;
    endtask

    task automatic compare_all();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("rom_addr", 32'(rom_addr), 32'(m_pc));
        chk("reg0", 32'(reg0), 32'(m_reg[0]));
        chk("reg1", 32'(reg1), 32'(m_reg[1]));
        chk("reg2", 32'(reg2), 32'(m_reg[2]));
        chk("reg3", 32'(reg3), 32'(m_reg[3]));
        chk("waiting", 32'(waiting), 32'(m_mode == 1));
        chk("halted", 32'(halted), 32'(m_mode == 2));
    endtask

    task automatic step(input logic e, input logic [1:0] c);
        en = e;
        cond_in = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Enters reset at a falling edge; ROM may be reloaded before release.
    task automatic reset_on();
        reset = 1'b1;
        en = 1'b1;
        #1;
        model_reset();
        compare_all();
    endtask

    task automatic reset_off();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        int cnt;
        int budget;
        logic was_wait;
        reset = 1'b1; en = 1'b1; cond_in = 2'b10;
        clear_rom();
        model_reset();
        @(negedge clk);
        reset_on();

        // Program 1: write, conditional self-jump, waits, wrap-around.
        rom[0]  = mk(0, 1, 1, 8'h01);
        rom[1]  = mk(0, 0, 0, 0);
        rom[2]  = mk(4, 2, 0, 2);
        rom[3]  = mk(0, 3, 0, 3);
        rom[4]  = mk(0, 3, 0, 0);
        rom[5]  = mk(0, 2, 0, 30);
        rom[30] = mk(6, 1, 3, 8'h3C);
        rom[31] = mk(0, 0, 0, 0);
        reset_off();
        step(1'b1, 2'b10);
        chk("first_write_reg1", 32'(reg1), 32'h01);
        chk("first_write_pc", 32'(pc), 32'd1);
        chk("first_write_reg0", 32'(reg0), 32'h00);
        for (int i = 0; i < 10; i++) step(1'b1, 2'b10);
        chk("busy_wait_pc", 32'(pc), 32'd2);
        cnt = 0;
        while (pc == 5'd2 && cnt < 10) begin
            step(1'b1, 2'b00);
            cnt++;
        end
        chk("sync_latency", 32'(cnt), 32'd3);
        step(1'b1, 2'b00);
        cnt = 0;
        budget = 0;
        while (waiting && budget < 50) begin
            cnt++;
            budget++;
            step(1'b1, 2'b00);
        end
        chk("wait_len", 32'(cnt), 32'd12);
        chk("after_wait_pc", 32'(pc), 32'd4);
        step(1'b1, 2'b00);
        chk("wait0_pc", 32'(pc), 32'd5);
        chk("wait0_waiting", 32'(waiting), 32'd0);
        step(1'b1, 2'b00);
        chk("jump30_pc", 32'(pc), 32'd30);
        step(1'b1, 2'b00);
        step(1'b1, 2'b00);
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("cond_false_nowrite", 32'(reg3), 32'h00);
        for (int i = 0; i < 20; i++) step(1'b1, 2'(i));

        // Program 2: truncated jump target, then halt.
        reset_on();
        clear_rom();
        rom[0] = mk(0, 2, 0, 8'hE5);
        rom[5] = mk(0, 4, 0, 0);
        reset_off();
        step(1'b1, 2'b00);
        chk("jump_e5_pc", 32'(pc), 32'd5);
        for (int i = 0; i < 100; i++) step(1'b1, 2'($urandom_range(0, 3)));
        chk("halt_pc", 32'(pc), 32'd5);
        chk("halt_flag", 32'(halted), 32'd1);
        reset_on();
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);

        // Program 3: pause mid-WAIT, then asynchronous reset mid-WAIT.
        clear_rom();
        rom[0] = mk(0, 3, 0, 5);
        rom[1] = mk(0, 4, 0, 0);
        reset_off();
        cnt = 0;
        for (int i = 0; i < 200 && !halted; i++) begin
            was_wait = waiting;
            step(!(i >= 6 && i < 16), 2'b00);
            if (en && was_wait) cnt++;
        end
        chk("paused_wait_len", 32'(cnt), 32'd20);
        reset_on();
        reset_off();
        for (int i = 0; i < 5; i++) step(1'b1, 2'b00);
        chk("pre_async_waiting", 32'(waiting), 32'd1);
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk("async_waiting", 32'(waiting), 32'd0);
        chk("async_pc", 32'(pc), 32'd0);
        reset_off();

        // Randomised programs with random enable and conditions.
        for (int prog = 0; prog < 6; prog++) begin
            reset_on();
            for (int i = 0; i < 32; i++) begin
                logic [15:0] w;
                w = 16'($urandom);
                if (w[12:10] == 3'd3) w[7:0] = w[7:0] & 8'h03;
                if (w[12:10] == 3'd4 && ($urandom_range(0, 3) != 0)) w[12:10] = 3'd0;
                rom[i] = w;
            end
            reset_off();
            for (int i = 0; i < 300; i++)
                step(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
